com_testx_sequencer: RTL and testbench
======================================

// Module: com_testx_sequencer
// PURPOSE
//  Command-side driver of the per-test decode path: accepts software test commands, drives
//  op_code_w_reset / op_code_w_execute / test_number to the test decoder, holds execute while
//  the selected test runs, and closes out on done, timeout, abort or reset. Status and elapsed
//  cycles are readable by software. Sits between the AXI register bank and the test decoder.
// PARAMETERS
//  NUM_TESTS      5        number of valid tests; valid test_number range is 1..NUM_TESTS
//  TIMEOUT_CYCLES 1048576  RUN cycles before forced TIMEOUT (>=2)
//  CNT_W          24       width of elapsed_cycles (saturating)
//  RST_CYCLES     2        length of op_code_w_reset pulse (>=1)
// PORTS
//  clk               in   1         clock (S_AXI_ACLK or pl_clk1)
//  reset             in   1         synchronous reset, active-high
//  cmd_valid         in   1         command handshake valid
//  cmd_ready         out  1         command handshake ready
//  cmd_opcode        in   2         00 NOP, 01 EXECUTE, 10 RESET, 11 ABORT
//  cmd_test_number   in   4         test to run (EXECUTE only)
//  test_done         in   NUM_TESTS bit i = test (i+1) finished (level or pulse)
//  op_code_w_reset   out  1         registered reset to test decoder
//  op_code_w_execute out  1         registered execute level to test decoder
//  test_number       out  4         registered test number to test decoder
//  busy              out  1         1 in any state other than IDLE
//  status            out  3         0 IDLE,1 RUNNING,2 DONE,3 TIMEOUT,4 ABORTED,5 ERR_BADTEST
//  done_pulse        out  1         one-cycle pulse on entry to IDLE from DRAIN
//  cmd_rejected      out  1         one-cycle pulse when an accepted command is refused
//  elapsed_cycles    out  CNT_W     RUN-cycle count of current/last test
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (cmd_ready 0 while reset high, 1 first cycle after).
//  - FSM IDLE, RUN, DRAIN, RST. cmd_ready = 1 in IDLE and RUN, 0 in DRAIN and RST.
//  - Handshake: command accepted on cmd_valid & cmd_ready; exactly one command per accept.
//  - IDLE: NOP/ABORT -> no effect. EXECUTE with 1<=cmd_test_number<=NUM_TESTS -> RUN; next
//    cycle test_number=cmd_test_number, op_code_w_execute=1, status=RUNNING, elapsed=0.
//    Out-of-range (0 or >NUM_TESTS) -> stay IDLE, status=ERR_BADTEST, cmd_rejected=1, outputs
//    to decoder unchanged.
//  - RUN: op_code_w_execute held 1, test_number stable; elapsed_cycles +1 per RUN cycle,
//    saturating at all-ones. Exit priority per cycle: RESET cmd > test_done[test_number-1]
//    (-> DONE) > ABORT cmd (-> ABORTED) > elapsed==TIMEOUT_CYCLES (-> TIMEOUT). DONE/ABORTED/
//    TIMEOUT -> DRAIN. test_done bits of other tests ignored. EXECUTE/NOP in RUN: EXECUTE
//    gives cmd_rejected=1, run unaffected; NOP ignored.
//  - DRAIN: op_code_w_execute=0 for exactly 1 cycle, test_number held; then IDLE with
//    done_pulse=1 for that first IDLE cycle. elapsed_cycles frozen until next EXECUTE.
//  - RESET cmd (IDLE or RUN) -> RST: op_code_w_execute=0 and op_code_w_reset=1 for
//    RST_CYCLES cycles starting cycle after accept; test_number=0; then IDLE, status=IDLE,
//    elapsed=0, no done_pulse.
//  - status sticky until next accepted EXECUTE or RESET.
//  - reset input mid-RUN: all outputs 0 next cycle; no done_pulse, no op_code_w_reset pulse.
//  - All outputs registered; latency accept->op_code_w_execute = 1 cycle.
// TESTING
//  1 EXECUTE test 3, test_done[2]=1 after 10 RUN cycles -> execute high 10 cycles, test_number
//    3, status DONE, elapsed=10, execute low 1 cycle, then single done_pulse.
//  2 EXECUTE test 0, then test 6 -> no execute, status 5, cmd_rejected each, busy stays 0.
//  3 TIMEOUT_CYCLES=16, EXECUTE test 1, no done -> status TIMEOUT, elapsed=16, DRAIN, IDLE.
//  4 EXECUTE test 2; cycle 5 ABORT with test_done[1]=1 same cycle -> status DONE; repeat with
//    test_done[0]=1 only -> ignored, status ABORTED.
//  5 RESET cmd during RUN -> op_code_w_reset=1 for 2 cycles, execute=0, test_number=0,
//    status IDLE, no done_pulse; EXECUTE during RUN -> cmd_rejected, test_number unchanged.
//  6 reset input asserted mid-RUN -> all outputs 0 next cycle; cmd_ready 1 after release.

Source files
------------

// File: rtl/com_testx_sequencer_if.sv
// Command handshake between the AXI register bank (master) and the test sequencer (slave).
interface com_testx_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [3:0] cmd_test_number;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_test_number,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_test_number,
        output cmd_ready
    );
endinterface

// File: rtl/com_testx_sequencer.sv
// Command-side driver of the per-test decode path: turns software commands into registered
// reset/execute/test_number to the test decoder and tracks status and elapsed RUN cycles.
module com_testx_sequencer #(
    parameter int NUM_TESTS      = 5,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 24,
    parameter int RST_CYCLES     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    com_testx_sequencer_if.slave cmd,
    input  logic [NUM_TESTS-1:0] test_done,
    output logic                 op_code_w_reset,
    output logic                 op_code_w_execute,
    output logic [3:0]           test_number,
    output logic                 busy,
    output logic [2:0]           status,
    output logic                 done_pulse,
    output logic                 cmd_rejected,
    output logic [CNT_W-1:0]     elapsed_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RST} state_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_DONE     = 3'd2,
        ST_TIMEOUT  = 3'd3,
        ST_ABORTED  = 3'd4,
        ST_BADTEST  = 3'd5
    } status_e;

    typedef enum logic [1:0] {OP_NOP, OP_EXECUTE, OP_RESET, OP_ABORT} opcode_e;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic             op_reset_q, op_reset_d;
    logic             execute_q, execute_d;
    logic [3:0]       test_number_q, test_number_d;
    logic             busy_q, busy_d;
    logic             done_pulse_q, done_pulse_d;
    logic             cmd_rejected_q, cmd_rejected_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;

    logic             accept;
    opcode_e          opcode;
    logic             test_ok;
    logic             done_sel;
    logic             go_rst;
    logic [CNT_W-1:0] elapsed_inc;

    always_comb begin
        accept      = cmd.cmd_valid & cmd_ready_q;
        opcode      = opcode_e'(cmd.cmd_opcode);
        test_ok     = (cmd.cmd_test_number != 4'd0) &&
                      (int'(cmd.cmd_test_number) <= NUM_TESTS);
        elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + CNT_W'(1);

        // Only the done bit of the test currently selected may end the run.
        done_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
            if (test_number_q == 4'(i + 1) && test_done[i]) done_sel = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        status_d       = status_q;
        op_reset_d     = op_reset_q;
        execute_d      = execute_q;
        test_number_d  = test_number_q;
        elapsed_d      = elapsed_q;
        rst_cnt_d      = rst_cnt_q;
        done_pulse_d   = 1'b0;
        cmd_rejected_d = 1'b0;
        go_rst         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_EXECUTE: begin
                            if (test_ok) begin
                                state_d       = S_RUN;
                                execute_d     = 1'b1;
                                test_number_d = cmd.cmd_test_number;
                                status_d      = ST_RUNNING;
                                elapsed_d     = '0;
                            end else begin
                                status_d       = ST_BADTEST;
                                cmd_rejected_d = 1'b1;
                            end
                        end
                        OP_RESET: go_rst = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // The exiting cycle is itself a RUN cycle, so it is counted too.
                elapsed_d = elapsed_inc;
                if (accept && opcode == OP_EXECUTE) cmd_rejected_d = 1'b1;
                if (accept && opcode == OP_RESET) begin
                    go_rst = 1'b1;
                end else if (done_sel) begin
                    state_d   = S_DRAIN;
                    execute_d = 1'b0;
                    status_d  = ST_DONE;
                end else if (accept && opcode == OP_ABORT) begin
                    state_d   = S_DRAIN;
                    execute_d = 1'b0;
                    status_d  = ST_ABORTED;
                end else if (elapsed_inc == TIMEOUT_VAL) begin
                    state_d   = S_DRAIN;
                    execute_d = 1'b0;
                    status_d  = ST_TIMEOUT;
                end
            end
            S_DRAIN: begin
                state_d      = S_IDLE;
                done_pulse_d = 1'b1;
            end
            S_RST: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d    = S_IDLE;
                    op_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_rst) begin
            state_d       = S_RST;
            op_reset_d    = 1'b1;
            execute_d     = 1'b0;
            test_number_d = 4'd0;
            status_d      = ST_IDLE;
            elapsed_d     = '0;
            rst_cnt_d     = '0;
        end

        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            status_q       <= ST_IDLE;
            op_reset_q     <= 1'b0;
            execute_q      <= 1'b0;
            test_number_q  <= 4'd0;
            busy_q         <= 1'b0;
            done_pulse_q   <= 1'b0;
            cmd_rejected_q <= 1'b0;
            cmd_ready_q    <= 1'b0;
            elapsed_q      <= '0;
            rst_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            op_reset_q     <= op_reset_d;
            execute_q      <= execute_d;
            test_number_q  <= test_number_d;
            busy_q         <= busy_d;
            done_pulse_q   <= done_pulse_d;
            cmd_rejected_q <= cmd_rejected_d;
            cmd_ready_q    <= cmd_ready_d;
            elapsed_q      <= elapsed_d;
            rst_cnt_q      <= rst_cnt_d;
        end
    end

    assign cmd.cmd_ready       = cmd_ready_q;
    assign op_code_w_reset     = op_reset_q;
    assign op_code_w_execute   = execute_q;
    assign test_number         = test_number_q;
    assign busy                = busy_q;
    assign status              = status_q;
    assign done_pulse          = done_pulse_q;
    assign cmd_rejected        = cmd_rejected_q;
    assign elapsed_cycles      = elapsed_q;

endmodule

// File: tb/tb_com_testx_sequencer.sv
// Directed bench for com_testx_sequencer: run/done, bad test, timeout, abort priority,
// reset command and reset input mid-run.
module tb_com_testx_sequencer;

    localparam int NUM_TESTS = 5;
    localparam int CNT_W     = 24;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_EXEC = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_ABRT = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_TESTS-1:0] test_done;
    logic                 op_code_w_reset;
    logic                 op_code_w_execute;
    logic [3:0]           test_number;
    logic                 busy;
    logic [2:0]           status;
    logic                 done_pulse;
    logic                 cmd_rejected;
    logic [CNT_W-1:0]     elapsed_cycles;

    int checks = 0;
    int errors = 0;

    com_testx_sequencer_if cmd_bus ();

    com_testx_sequencer #(
        .NUM_TESTS      (NUM_TESTS),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CNT_W),
        .RST_CYCLES     (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd               (cmd_bus),
        .test_done         (test_done),
        .op_code_w_reset   (op_code_w_reset),
        .op_code_w_execute (op_code_w_execute),
        .test_number       (test_number),
        .busy              (busy),
        .status            (status),
        .done_pulse        (done_pulse),
        .cmd_rejected      (cmd_rejected),
        .elapsed_cycles    (elapsed_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] num);
        cmd_bus.cmd_valid       = 1'b1;
        cmd_bus.cmd_opcode      = op;
        cmd_bus.cmd_test_number = num;
        tick();
        cmd_bus.cmd_valid       = 1'b0;
        cmd_bus.cmd_opcode      = OP_NOP;
        cmd_bus.cmd_test_number = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ex_cnt;

        reset                   = 1'b1;
        test_done               = '0;
        cmd_bus.cmd_valid       = 1'b0;
        cmd_bus.cmd_opcode      = OP_NOP;
        cmd_bus.cmd_test_number = 4'd0;
        tick(); tick(); tick();
        check_eq("rst_ready",   32'(cmd_bus.cmd_ready), 0);
        check_eq("rst_busy",    32'(busy), 0);
        check_eq("rst_status",  32'(status), 0);
        check_eq("rst_exec",    32'(op_code_w_execute), 0);
        check_eq("rst_opreset", 32'(op_code_w_reset), 0);
        check_eq("rst_tn",      32'(test_number), 0);
        check_eq("rst_elapsed", 32'(elapsed_cycles), 0);
        reset = 1'b0;
        tick();
        check_eq("rel_ready", 32'(cmd_bus.cmd_ready), 1);

        // 1: test 3 finishes after 10 RUN cycles
        send(OP_EXEC, 4'd3);
        check_eq("t1_exec",    32'(op_code_w_execute), 1);
        check_eq("t1_tn",      32'(test_number), 3);
        check_eq("t1_status",  32'(status), 1);
        check_eq("t1_el0",     32'(elapsed_cycles), 0);
        check_eq("t1_busy",    32'(busy), 1);
        ex_cnt = 1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (op_code_w_execute) ex_cnt++;
        end
        check_eq("t1_el9", 32'(elapsed_cycles), 9);
        test_done = 5'b00100;
        tick();
        test_done = '0;
        check_eq("t1_exec_cnt",   32'(ex_cnt), 10);
        check_eq("t1_exec_off",   32'(op_code_w_execute), 0);
        check_eq("t1_status_dn",  32'(status), 2);
        check_eq("t1_el10",       32'(elapsed_cycles), 10);
        check_eq("t1_tn_drain",   32'(test_number), 3);
        check_eq("t1_ready_drn",  32'(cmd_bus.cmd_ready), 0);
        check_eq("t1_nopulse",    32'(done_pulse), 0);
        tick();
        check_eq("t1_pulse",      32'(done_pulse), 1);
        check_eq("t1_busy_idle",  32'(busy), 0);
        check_eq("t1_el_frozen",  32'(elapsed_cycles), 10);
        tick();
        check_eq("t1_pulse_once", 32'(done_pulse), 0);

        // 2: out-of-range tests
        send(OP_EXEC, 4'd0);
        check_eq("t2_rej0",    32'(cmd_rejected), 1);
        check_eq("t2_status0", 32'(status), 5);
        check_eq("t2_busy0",   32'(busy), 0);
        check_eq("t2_exec0",   32'(op_code_w_execute), 0);
        check_eq("t2_tn0",     32'(test_number), 3);
        tick();
        check_eq("t2_rej_clr", 32'(cmd_rejected), 0);
        send(OP_EXEC, 4'd6);
        check_eq("t2_rej6",    32'(cmd_rejected), 1);
        check_eq("t2_status6", 32'(status), 5);
        check_eq("t2_busy6",   32'(busy), 0);
        tick();

        // 3: timeout at 16 RUN cycles
        send(OP_EXEC, 4'd1);
        check_eq("t3_tn", 32'(test_number), 1);
        n = 0;
        while (op_code_w_execute && n < 40) begin
            tick();
            n++;
        end
        check_eq("t3_run_len", 32'(n), 16);
        check_eq("t3_status",  32'(status), 3);
        check_eq("t3_el16",    32'(elapsed_cycles), 16);
        check_eq("t3_busy",    32'(busy), 1);
        tick();
        check_eq("t3_pulse",   32'(done_pulse), 1);
        check_eq("t3_idle",    32'(busy), 0);
        tick();

        // 4: done beats abort in the same cycle; other tests' done bits ignored
        send(OP_EXEC, 4'd2);
        tick(); tick(); tick(); tick();
        test_done = 5'b00010;
        send(OP_ABRT, 4'd0);
        test_done = '0;
        check_eq("t4_status_dn", 32'(status), 2);
        check_eq("t4_el5",       32'(elapsed_cycles), 5);
        tick();
        check_eq("t4_pulse",     32'(done_pulse), 1);
        tick();
        send(OP_EXEC, 4'd2);
        tick(); tick(); tick(); tick();
        test_done = 5'b00001;
        send(OP_ABRT, 4'd0);
        test_done = '0;
        check_eq("t4_status_ab", 32'(status), 4);
        check_eq("t4_exec_off",  32'(op_code_w_execute), 0);
        check_eq("t4_el5b",      32'(elapsed_cycles), 5);
        tick();
        check_eq("t4_pulse2",    32'(done_pulse), 1);
        tick();

        // 5: EXECUTE during RUN rejected, then RESET command
        send(OP_EXEC, 4'd4);
        tick(); tick();
        send(OP_EXEC, 4'd2);
        check_eq("t5_rej",      32'(cmd_rejected), 1);
        check_eq("t5_tn_keep",  32'(test_number), 4);
        check_eq("t5_exec_on",  32'(op_code_w_execute), 1);
        check_eq("t5_status",   32'(status), 1);
        tick();
        send(OP_RST, 4'd0);
        check_eq("t5_opreset1", 32'(op_code_w_reset), 1);
        check_eq("t5_exec_off", 32'(op_code_w_execute), 0);
        check_eq("t5_tn0",      32'(test_number), 0);
        check_eq("t5_st_idle",  32'(status), 0);
        check_eq("t5_el0",      32'(elapsed_cycles), 0);
        check_eq("t5_ready0",   32'(cmd_bus.cmd_ready), 0);
        tick();
        check_eq("t5_opreset2", 32'(op_code_w_reset), 1);
        tick();
        check_eq("t5_opreset3", 32'(op_code_w_reset), 0);
        check_eq("t5_busy",     32'(busy), 0);
        check_eq("t5_nopulse",  32'(done_pulse), 0);
        check_eq("t5_ready1",   32'(cmd_bus.cmd_ready), 1);
        tick();
        check_eq("t5_nopulse2", 32'(done_pulse), 0);

        // 6: reset input mid-RUN
        send(OP_EXEC, 4'd5);
        tick(); tick(); tick();
        check_eq("t6_el3", 32'(elapsed_cycles), 3);
        reset = 1'b1;
        tick();
        check_eq("t6_exec",    32'(op_code_w_execute), 0);
        check_eq("t6_tn",      32'(test_number), 0);
        check_eq("t6_status",  32'(status), 0);
        check_eq("t6_el",      32'(elapsed_cycles), 0);
        check_eq("t6_busy",    32'(busy), 0);
        check_eq("t6_ready",   32'(cmd_bus.cmd_ready), 0);
        check_eq("t6_opreset", 32'(op_code_w_reset), 0);
        reset = 1'b0;
        tick();
        check_eq("t6_ready1",  32'(cmd_bus.cmd_ready), 1);
        check_eq("t6_nopulse", 32'(done_pulse), 0);
        check_eq("t6_noorst",  32'(op_code_w_reset), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
